ucie_txrx_mode_sequencer: RTL and testbench
===========================================

# ucie_txrx_mode_sequencer

Sequences per-channel TX/RX direction changes for the two-channel UCIe channel adapter. It takes a requested 4-bit txrx_mode from the CSR/software side, waits for mainband traffic to drain, and forces the changing channels to hi-Z for a guard interval. It then clears the RX FIFO when a channel turns to RX and lets the pads settle before re-enabling UCIe mode. It sits in the `clk` domain between the synchronized CSR controls and the channel adapter's `i_txrx_mode` / `i_rxfifo_clr` / `ucie_mode_en` inputs.

## Interface
- HIZ_CYCLES, 8: guard cycles with changing channels at 2'b00 (1..255)
- CLR_CYCLES, 2: RX FIFO clear pulse length (1..15)
- SETTLE_CYCLES, 4: cycles new mode is applied before mode_en returns (1..255)
- DRAIN_TIMEOUT, 255: max cycles to wait for traffic idle (1..65535)

Ports:
- clk  in  1  adapter core clock; the only clock
- rst  in  1  synchronous, active-high reset
- i_req_vld  in  1  mode-change request valid
- i_req_mode  in  4  target mode; [1:0] ch0, [3:2] ch1; 00 hi-Z, 01 RX, 10 TX, 11 reserved
- o_req_rdy  out  1  sequencer can accept a request
- i_traffic_busy  in  1  mainband in flight (lp_valid | pl_valid | TX FIFO non-empty)
- o_txrx_mode  out  4  mode driven to the channel adapter
- o_rxfifo_clr  out  1  RX FIFO clear
- o_ucie_mode_en  out  1  UCIe mode enable
- o_busy  out  1  sequence in progress
- o_done  out  1  one-cycle pulse: request completed
- o_err  out  1  one-cycle pulse: request rejected or timed out
- o_err_code  out  2  01 reserved mode, 10 drain timeout; held until next accept

## Operation
- Reset values: o_txrx_mode=0000, o_rxfifo_clr=0, o_ucie_mode_en=0, o_busy=0, o_done=0, o_err=0, o_err_code=00, o_req_rdy=1, state IDLE.
- Accept: `i_req_vld & o_req_rdy`. o_req_rdy=1 only in IDLE. Mode and change mask (per channel: target≠current) are latched on accept.
- Reserved check: either channel field =11 → o_err=1 and o_err_code=01 next cycle, stay IDLE, no output change.
- No-change request (mask=0) → o_done next cycle, outputs untouched.
- States:
  - IDLE
  - DRAIN: o_ucie_mode_en=0. Exit to HIZ on the first cycle that samples i_traffic_busy=0. After DRAIN_TIMEOUT cycles busy → abort to IDLE, o_err with code 10, o_txrx_mode unchanged, o_ucie_mode_en restored to its pre-request value.
  - HIZ: masked channels driven 00, unmasked channels hold.
  - CLR: o_rxfifo_clr=1. Entered only if some masked channel's target is 01, else skipped.
  - SETTLE: o_txrx_mode=target, o_ucie_mode_en=0.
  - DONE: o_done=1. o_ucie_mode_en = (any channel of the target is 01 or 10). Next state IDLE.
- o_busy=1 in every state except IDLE.
- i_req_vld while busy is ignored; the requester must hold it until o_req_rdy.
- One down-counter is shared by all phases. Width = clog2(max parameter + 1). Reloaded on each state entry; exit when it reaches 1.

## Timing
- Accept at edge 0, change to RX, busy already low:
  - DRAIN: cycle 1
  - HIZ: cycles 2..(1+HIZ_CYCLES)
  - CLR: next CLR_CYCLES
  - SETTLE: next SETTLE_CYCLES
  - DONE: o_done pulse on the following cycle
  - o_req_rdy=1 on the cycle after that
- Default parameters: o_done at cycle 16, o_req_rdy at cycle 17. Without CLR: o_done at cycle 14.
- Each extra busy cycle in DRAIN adds one cycle.
- Timeout: o_err at cycle 1+DRAIN_TIMEOUT when busy is held.
- All outputs are registered; no combinational path from inputs to outputs.
- rst mid-sequence: next cycle every output is at its reset value (o_txrx_mode=0000, i.e. all hi-Z), state IDLE, the pending request is dropped.

## Test plan
- Reset then request 0110 (ch0 TX, ch1 RX), busy=0 → o_txrx_mode 0000 through cycles 1..9, o_rxfifo_clr high cycles 10-11, 0110 from cycle 12, o_ucie_mode_en=1 with o_done at 16.
- From 0110, request 0101 (only ch0 changes, to RX) → bits [3:2] stay 01 throughout, [1:0] go 00 in HIZ, CLR runs, done at 16.
- From 0101, request 1010 (both to TX) → CLR skipped, o_rxfifo_clr never high, o_done at 14.
- Request 0011 → o_err=1 with code 01 at cycle 1, o_txrx_mode unchanged, o_req_rdy stays 1.
- Hold i_traffic_busy=1 with DRAIN_TIMEOUT=255 → o_err with code 10 at cycle 256, mode unchanged, o_ucie_mode_en restored.
- Busy released at cycle 5 → HIZ starts at cycle 6. Assert rst at cycle 8 → cycle 9 all outputs at reset values, o_req_rdy=1. Request equal to the current mode → o_done at cycle 1, no output toggle.

Source files
------------

// File: rtl/ucie_txrx_mode_sequencer_if.sv
// Mode-change request and channel-adapter control bundle for
// ucie_txrx_mode_sequencer. The master side is the CSR requester plus the
// traffic monitor. The slave side is the sequencer itself.
interface ucie_txrx_mode_sequencer_if;

  // Request handshake from the synchronized CSR side
  logic       i_req_vld;
  logic [3:0] i_req_mode;
  logic       o_req_rdy;

  // Mainband activity indication (lp_valid | pl_valid | TX FIFO non-empty)
  logic       i_traffic_busy;

  // Controls toward the channel adapter
  logic [3:0] o_txrx_mode;
  logic       o_rxfifo_clr;
  logic       o_ucie_mode_en;

  // Sequencer status
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [1:0] o_err_code;

  modport master (
    output i_req_vld,
    output i_req_mode,
    output i_traffic_busy,
    input  o_req_rdy,
    input  o_txrx_mode,
    input  o_rxfifo_clr,
    input  o_ucie_mode_en,
    input  o_busy,
    input  o_done,
    input  o_err,
    input  o_err_code
  );

  modport slave (
    input  i_req_vld,
    input  i_req_mode,
    input  i_traffic_busy,
    output o_req_rdy,
    output o_txrx_mode,
    output o_rxfifo_clr,
    output o_ucie_mode_en,
    output o_busy,
    output o_done,
    output o_err,
    output o_err_code
  );

endinterface

// File: rtl/ucie_txrx_mode_sequencer.sv
// Per-channel TX/RX direction change sequencer for the two-channel UCIe
// channel adapter. A requested mode is accepted, mainband traffic is
// drained, and the changing channels are parked at hi-Z for a guard
// interval. The RX FIFO is cleared when a channel turns to RX. The new mode
// then settles before UCIe mode is enabled again. All outputs are registered.
module ucie_txrx_mode_sequencer #(
  parameter int HIZ_CYCLES    = 8,    // 1..255
  parameter int CLR_CYCLES    = 2,    // 1..15
  parameter int SETTLE_CYCLES = 4,    // 1..255
  parameter int DRAIN_TIMEOUT = 255   // 1..65535
) (
  input  logic                         clk,
  input  logic                         rst,
  ucie_txrx_mode_sequencer_if.slave    bus
);

  // Channel field encodings
  localparam logic [1:0] CH_HIZ = 2'b00;
  localparam logic [1:0] CH_RX  = 2'b01;
  localparam logic [1:0] CH_TX  = 2'b10;
  localparam logic [1:0] CH_RSV = 2'b11;

  // Error codes
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RSVD    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Sequencer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRAIN  = 3'd1;
  localparam logic [2:0] ST_HIZ    = 3'd2;
  localparam logic [2:0] ST_CLR    = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // One shared down-counter covers every timed phase, so it is sized for
  // the largest phase length.
  localparam int MAX_A = (HIZ_CYCLES > CLR_CYCLES) ? HIZ_CYCLES : CLR_CYCLES;
  localparam int MAX_B = (SETTLE_CYCLES > DRAIN_TIMEOUT) ? SETTLE_CYCLES : DRAIN_TIMEOUT;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_DRAIN   = CNT_W'(DRAIN_TIMEOUT);
  localparam logic [CNT_W-1:0] LD_HIZ     = CNT_W'(HIZ_CYCLES);
  localparam logic [CNT_W-1:0] LD_CLR     = CNT_W'(CLR_CYCLES);
  localparam logic [CNT_W-1:0] LD_SETTLE  = CNT_W'(SETTLE_CYCLES);

  // Control state
  logic [2:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       tgt_q;       // latched target mode
  logic [1:0]       mask_q;      // per-channel "target differs from current"
  logic             saved_en_q;  // ucie_mode_en before the request, for abort

  // Registered outputs
  logic       req_rdy_q;
  logic [3:0] txrx_mode_q;
  logic       rxfifo_clr_q;
  logic       mode_en_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic [1:0] err_code_q;

  // Decoded request and sequence properties
  logic       accept;
  logic       req_reserved;
  logic [1:0] req_mask;
  logic [3:0] hiz_mode;
  logic       need_clr;
  logic       tgt_active;
  logic       cnt_last;

  // Decode the incoming request and the latched target into control flags.
  // NOTE: every signal driven here gets a default first so no branch can leave it unassigned and infer a latch.
  always_comb begin
    accept       = 1'b0;
    req_reserved = 1'b0;
    req_mask     = 2'b00;
    hiz_mode     = txrx_mode_q;
    need_clr     = 1'b0;
    tgt_active   = 1'b0;
    cnt_last     = 1'b0;

    accept       = bus.i_req_vld & req_rdy_q;
    req_reserved = (bus.i_req_mode[1:0] == CH_RSV) | (bus.i_req_mode[3:2] == CH_RSV);
    req_mask[0]  = (bus.i_req_mode[1:0] != txrx_mode_q[1:0]);
    req_mask[1]  = (bus.i_req_mode[3:2] != txrx_mode_q[3:2]);

    // Changing channels are parked at hi-Z; the others keep their mode.
    hiz_mode[1:0] = mask_q[0] ? CH_HIZ : txrx_mode_q[1:0];
    hiz_mode[3:2] = mask_q[1] ? CH_HIZ : txrx_mode_q[3:2];

    // The FIFO clear only runs when a channel actually turns to RX.
    need_clr   = (mask_q[0] & (tgt_q[1:0] == CH_RX)) |
                 (mask_q[1] & (tgt_q[3:2] == CH_RX));
    tgt_active = (tgt_q[1:0] == CH_RX) | (tgt_q[1:0] == CH_TX) |
                 (tgt_q[3:2] == CH_RX) | (tgt_q[3:2] == CH_TX);

    cnt_last   = (cnt_q == CNT_ONE);
  end

  // Sequencer FSM, shared phase counter and registered outputs.
  // NOTE: registers update with <= so each one samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tgt_q        <= 4'b0000;
      mask_q       <= 2'b00;
      saved_en_q   <= 1'b0;
      req_rdy_q    <= 1'b1;
      txrx_mode_q  <= 4'b0000;
      rxfifo_clr_q <= 1'b0;
      mode_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      // Completion and error indications are single-cycle pulses.
      done_q <= 1'b0;
      err_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (req_reserved) begin
              // Rejected: nothing but the error status changes.
              err_q      <= 1'b1;
              err_code_q <= ERR_RSVD;
            end else if (req_mask == 2'b00) begin
              // Already in the requested mode: complete without a sequence.
              err_code_q <= ERR_NONE;
              done_q     <= 1'b1;
            end else begin
              err_code_q <= ERR_NONE;
              tgt_q      <= bus.i_req_mode;
              mask_q     <= req_mask;
              saved_en_q <= mode_en_q;
              mode_en_q  <= 1'b0;
              busy_q     <= 1'b1;
              req_rdy_q  <= 1'b0;
              cnt_q      <= LD_DRAIN;
              state_q    <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (!bus.i_traffic_busy) begin
            txrx_mode_q <= hiz_mode;
            cnt_q       <= LD_HIZ;
            state_q     <= ST_HIZ;
          end else if (cnt_last) begin
            // Traffic never drained: abandon the request and restore enable.
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            mode_en_q  <= saved_en_q;
            busy_q     <= 1'b0;
            req_rdy_q  <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        ST_HIZ: begin
          if (cnt_last) begin
            if (need_clr) begin
              rxfifo_clr_q <= 1'b1;
              cnt_q        <= LD_CLR;
              state_q      <= ST_CLR;
            end else begin
              txrx_mode_q <= tgt_q;
              cnt_q       <= LD_SETTLE;
              state_q     <= ST_SETTLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        ST_CLR: begin
          if (cnt_last) begin
            rxfifo_clr_q <= 1'b0;
            txrx_mode_q  <= tgt_q;
            cnt_q        <= LD_SETTLE;
            state_q      <= ST_SETTLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        ST_SETTLE: begin
          if (cnt_last) begin
            // UCIe mode only comes back if some channel is actively used.
            mode_en_q <= tgt_active;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        ST_DONE: begin
          busy_q    <= 1'b0;
          req_rdy_q <= 1'b1;
          state_q   <= ST_IDLE;
        end

        default: begin
          rxfifo_clr_q <= 1'b0;
          busy_q       <= 1'b0;
          req_rdy_q    <= 1'b1;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_req_rdy      = req_rdy_q;
  assign bus.o_txrx_mode    = txrx_mode_q;
  assign bus.o_rxfifo_clr   = rxfifo_clr_q;
  assign bus.o_ucie_mode_en = mode_en_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_err          = err_q;
  assign bus.o_err_code     = err_code_q;

endmodule

// File: tb/tb_ucie_txrx_mode_sequencer.sv
// Self-checking bench for ucie_txrx_mode_sequencer. A directed table of
// requests carries hand-derived milestones. Hand-written sequences cover
// reset in mid-sequence and the no-change request. Randomized requests are
// compared cycle by cycle against a timeline model of the mode-change rules.
module tb_ucie_txrx_mode_sequencer;

  localparam int H = 8;
  localparam int C = 2;
  localparam int S = 4;
  localparam int T = 255;

  // Output vector: {rdy, mode[3:0], clr, en, busy, done, err, code[1:0]}
  localparam logic [11:0] RST_VEC = 12'b1_0000_0_0_0_0_0_00;

  logic clk;
  logic rst;

  ucie_txrx_mode_sequencer_if bus ();

  ucie_txrx_mode_sequencer #(
    .HIZ_CYCLES   (H),
    .CLR_CYCLES   (C),
    .SETTLE_CYCLES(S),
    .DRAIN_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: what the adapter looks like between requests
  logic [3:0] m_cur;
  logic       m_en;
  logic [1:0] m_code;
  logic [3:0] m_req;
  int         m_d;

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, got, exp);
    end
  endtask

  function automatic logic [11:0] dut_vec();
    return {bus.o_req_rdy, bus.o_txrx_mode, bus.o_rxfifo_clr, bus.o_ucie_mode_en,
            bus.o_busy, bus.o_done, bus.o_err, bus.o_err_code};
  endfunction

  function automatic bit m_reserved();
    return (m_req[1:0] == 2'b11) || (m_req[3:2] == 2'b11);
  endfunction

  function automatic bit m_active(input logic [3:0] md);
    return (md[1:0] == 2'b01) || (md[1:0] == 2'b10) ||
           (md[3:2] == 2'b01) || (md[3:2] == 2'b10);
  endfunction

  // Length of the FIFO clear: only when a changing channel becomes RX
  function automatic int m_clr_len();
    bit rx0, rx1;
    rx0 = (m_req[1:0] != m_cur[1:0]) && (m_req[1:0] == 2'b01);
    rx1 = (m_req[3:2] != m_cur[3:2]) && (m_req[3:2] == 2'b01);
    return (rx0 || rx1) ? C : 0;
  endfunction

  // Cycle at which the request finishes (done or err pulse)
  function automatic int model_end();
    if (m_reserved() || (m_req == m_cur)) return 1;
    if (m_d >= T) return 1 + T;
    return 2 + m_d + H + m_clr_len() + S;
  endfunction

  // Expected output vector at cycle c after the accepting edge
  function automatic logic [11:0] exp_at(input int c);
    logic [3:0] mode, hizm;
    logic       rdy, clr, en, busy, done, err;
    logic [1:0] code;
    int         hs, cs, ss, dc;
    mode = m_cur; en = m_en; code = m_code;
    rdy = 1'b1; clr = 1'b0; busy = 1'b0; done = 1'b0; err = 1'b0;
    if (m_reserved()) begin
      err  = (c == 1);
      code = 2'b01;
    end else if (m_req == m_cur) begin
      done = (c == 1);
      code = 2'b00;
    end else if (m_d >= T) begin
      err  = (c == 1 + T);
      code = (c >= 1 + T) ? 2'b10 : 2'b00;
      busy = (c < 1 + T);
      rdy  = (c >= 1 + T);
      en   = (c < 1 + T) ? 1'b0 : m_en;
    end else begin
      hs = 2 + m_d;
      cs = hs + H;
      ss = cs + m_clr_len();
      dc = ss + S;
      hizm[1:0] = (m_req[1:0] != m_cur[1:0]) ? 2'b00 : m_cur[1:0];
      hizm[3:2] = (m_req[3:2] != m_cur[3:2]) ? 2'b00 : m_cur[3:2];
      mode = (c < hs) ? m_cur : (c < ss) ? hizm : m_req;
      clr  = (c >= cs) && (c < ss);
      en   = (c < dc) ? 1'b0 : m_active(m_req);
      busy = (c <= dc);
      rdy  = (c > dc);
      done = (c == dc);
      code = 2'b00;
    end
    return {rdy, mode, clr, en, busy, done, err, code};
  endfunction

  // Issue one request with d busy cycles in DRAIN, optionally spraying
  // ignored requests while busy, and compare every cycle with the model.
  task automatic run_req(input logic [3:0] mode, input int d, input bit junk,
                         output int first_evt, output logic [11:0] last_vec,
                         output int clr_cnt);
    int         last;
    logic [11:0] v;
    m_req = mode;
    m_d   = d;
    last  = model_end() + 1;
    first_evt = 0;
    clr_cnt   = 0;
    v = '0;
    #1;
    bus.i_req_vld      = 1'b1;
    bus.i_req_mode     = mode;
    bus.i_traffic_busy = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      #1;
      bus.i_traffic_busy = (c <= d);
      if (junk && (c < last - 1) && ($urandom_range(0, 1) == 1)) begin
        bus.i_req_vld  = 1'b1;
        bus.i_req_mode = 4'($urandom_range(0, 15));
      end else begin
        bus.i_req_vld  = 1'b0;
      end
      @(negedge clk);
      v = dut_vec();
      check("cycle", c, v, exp_at(c));
      if ((first_evt == 0) && (v[3] || v[2])) first_evt = c;
      if (v[6]) clr_cnt++;
      @(posedge clk);
    end
    last_vec = v;
    #1;
    bus.i_req_vld      = 1'b0;
    bus.i_traffic_busy = 1'b0;
    // Advance the model to the post-request adapter state
    if (m_reserved()) begin
      m_code = 2'b01;
    end else if (m_req == m_cur) begin
      m_code = 2'b00;
    end else if (m_d >= T) begin
      m_code = 2'b10;
    end else begin
      m_cur  = m_req;
      m_en   = m_active(m_req);
      m_code = 2'b00;
    end
  endtask

  typedef struct {
    logic [3:0] mode;
    int         drain;
    int         end_cyc;
    logic [3:0] end_mode;
    logic       end_en;
    logic [1:0] end_code;
    int         clr_cyc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int          fe, cc, r, d;
    logic [11:0] lv, exp;
    logic [3:0]  mode;

    tbl[0] = '{4'b0110, 0,   16,  4'b0110, 1'b1, 2'b00, 2};  // ch0 TX, ch1 RX
    tbl[1] = '{4'b0101, 0,   16,  4'b0101, 1'b1, 2'b00, 2};  // only ch0 -> RX
    tbl[2] = '{4'b1010, 0,   14,  4'b1010, 1'b1, 2'b00, 0};  // both TX, no clear
    tbl[3] = '{4'b0011, 0,   1,   4'b1010, 1'b1, 2'b01, 0};  // reserved field
    tbl[4] = '{4'b1010, 0,   1,   4'b1010, 1'b1, 2'b00, 0};  // no change
    tbl[5] = '{4'b0001, 300, 256, 4'b1010, 1'b1, 2'b10, 0};  // drain timeout
    tbl[6] = '{4'b0000, 3,   17,  4'b0000, 1'b0, 2'b00, 0};  // all hi-Z, late drain
    tbl[7] = '{4'b1001, 0,   16,  4'b1001, 1'b1, 2'b00, 2};  // ch0 RX, ch1 TX

    rst                = 1'b1;
    bus.i_req_vld      = 1'b0;
    bus.i_req_mode     = 4'b0000;
    bus.i_traffic_busy = 1'b0;
    m_cur = 4'b0000; m_en = 1'b0; m_code = 2'b00; m_req = 4'b0000; m_d = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", 0, dut_vec(), RST_VEC);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset", 1, dut_vec(), RST_VEC);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].mode, tbl[i].drain, 1'b1, fe, lv, cc);
      check("end_cyc",  i, fe,        tbl[i].end_cyc);
      check("end_mode", i, lv[10:7],  tbl[i].end_mode);
      check("end_en",   i, lv[5],     tbl[i].end_en);
      check("end_code", i, lv[1:0],   tbl[i].end_code);
      check("clr_cyc",  i, cc,        tbl[i].clr_cyc);
    end

    // From 1001: request 0110, busy through cycle 4, reset during cycle 8
    #1;
    bus.i_req_vld      = 1'b1;
    bus.i_req_mode     = 4'b0110;
    bus.i_traffic_busy = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      #1;
      bus.i_req_vld      = 1'b0;
      bus.i_traffic_busy = (c <= 4);
      rst                = (c == 8);
      @(negedge clk);
      exp = (c <= 5) ? 12'b0_1001_0_0_1_0_0_00 :
            (c <= 8) ? 12'b0_0000_0_0_1_0_0_00 : RST_VEC;
      check("rst_mid", c, dut_vec(), exp);
      @(posedge clk);
    end

    // Request equal to the reset mode: immediate done, nothing else moves
    #1;
    rst            = 1'b0;
    bus.i_req_vld  = 1'b1;
    bus.i_req_mode = 4'b0000;
    @(posedge clk);
    for (int c = 1; c <= 2; c++) begin
      #1;
      bus.i_req_vld = 1'b0;
      @(negedge clk);
      exp = (c == 1) ? 12'b1_0000_0_0_0_1_0_00 : 12'b1_0000_0_0_0_0_0_00;
      check("nochg", c, dut_vec(), exp);
      @(posedge clk);
    end
    m_cur = 4'b0000; m_en = 1'b0; m_code = 2'b00;

    // Randomized requests against the timeline model
    for (int k = 0; k < 25; k++) begin
      mode = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) mode = m_cur;
      r = int'($urandom_range(0, 9));
      d = (r == 0) ? 253 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 6));
      run_req(mode, d, 1'b1, fe, lv, cc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
